// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Sequences PLL power-up from the reference-clock domain. Holds the PLL in
//   reset for a fixed time, waits (bounded) for LOCK, qualifies LOCK over a
//   stability window and only then releases the downstream active-low reset.
//   A LOCK timeout re-resets the PLL; after MAX_RETRIES timeouts without
//   reaching RUN the block latches a fault that only reset_n clears. Loss of
//   lock while running pulses lock_lost and restarts the whole sequence.
//
// Ports:
//   clkin        in   reference clock (same net as PLL CLKIN, never PLL output)
//   reset_n      in   asynchronous active-low reset
//   pll_lock     in   PLL LOCK, asynchronous; synchronized internally
//   pll_reset    out  PLL RESET, active high
//   rst_out_n    out  downstream reset, active low, high only in RUN
//   locked       out  high only in RUN
//   lock_lost    out  one-cycle pulse when RUN is left because lock dropped
//   fault        out  sticky, high in FAIL
//   retry_count  out  timeouts since last RUN entry, saturates at MAX_RETRIES
//   dbg_state    out  current FSM state encoding (observability only)
//
// Handshake: none; pll_lock is a level, all outputs are registered levels
// (lock_lost is a single-cycle registered pulse).
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 27,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 2700,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       rst_out_n,
    output logic       locked,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    // One counter is shared by every timed state, so size it for the longest.
    localparam int MAX_A  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW     = $clog2(MAX_CT + 1);

    // Terminal counts are "last cycle" values: the counter is 0 on the first
    // cycle in a state, so the Nth cycle sees N-1.
    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_retry;
    logic                   r_pll_reset;
    logic                   r_rst_out_n;
    logic                   r_locked;
    logic                   r_lock_lost;
    logic                   r_fault;

    logic                   w_lock_s;
    logic [3:0]             w_retry_next;

    // Plain shift-register synchronizer; bit 0 samples the asynchronous input.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign w_lock_s     = r_sync[SYNC_STAGES-1];
    assign w_retry_next = (r_retry == RETRY_MAX) ? r_retry : r_retry + 4'd1;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_retry     <= 4'd0;
            r_pll_reset <= 1'b1;
            r_rst_out_n <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            case (r_state)
                S_RESET_PLL: begin
                    r_pll_reset <= 1'b1;
                    if (r_cnt == RESET_LAST) begin
                        r_state     <= S_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock is tested first so a lock arriving on the timeout
                    // cycle wins and costs no retry.
                    if (w_lock_s) begin
                        r_state <= S_STABILIZE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_cnt       <= '0;
                        r_retry     <= w_retry_next;
                        r_pll_reset <= 1'b1;
                        if (w_retry_next == RETRY_MAX) begin
                            r_state <= S_FAIL;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= S_RESET_PLL;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STABILIZE: begin
                    if (!w_lock_s) begin
                        // Any drop restarts qualification with a new timeout.
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_rst_out_n <= 1'b1;
                        r_locked    <= 1'b1;
                        r_retry     <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    r_cnt <= '0;
                    if (!w_lock_s) begin
                        r_state     <= S_RESET_PLL;
                        r_rst_out_n <= 1'b0;
                        r_locked    <= 1'b0;
                        r_pll_reset <= 1'b1;
                        r_lock_lost <= 1'b1;
                    end
                end

                S_FAIL: begin
                    // Terminal until reset_n; outputs pinned to the fault values.
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_rst_out_n <= 1'b0;
                    r_locked    <= 1'b0;
                    r_fault     <= 1'b1;
                    r_retry     <= RETRY_MAX;
                end

                default: begin
                    r_state     <= S_RESET_PLL;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_rst_out_n <= 1'b0;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset   = r_pll_reset;
    assign rst_out_n   = r_rst_out_n;
    assign locked      = r_locked;
    assign lock_lost   = r_lock_lost;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with short timing parameters.
// Edge numbers below count clkin rising edges after reset_n release (edge 1
// is the first). Inputs change 1 ns after an edge; outputs are sampled there.
// With two sync stages, pll_lock driven after edge k is seen by the FSM at
// edge k+3 (lock_s is valid after edge k+2).
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int RESET_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int SYNC_STAGES   = 2;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    // ---------------- clock / reset ----------------
    logic       clkin;
    logic       reset_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       rst_out_n;
    logic       locked;
    logic       lock_lost;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] dbg_state;

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .RESET_CYCLES (RESET_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clkin      (clkin),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .rst_out_n  (rst_out_n),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .fault      (fault),
        .retry_count(retry_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) tick();
    endtask

    // Asserts reset_n immediately (possibly mid-cycle), checks that every
    // output reached its reset value before the next edge, then releases.
    task automatic do_reset(input string tag, input logic lock_val);
        reset_n  = 1'b0;
        pll_lock = lock_val;
        #1;
        check({tag, ".pll_reset"},   32'(pll_reset),   32'd1);
        check({tag, ".rst_out_n"},   32'(rst_out_n),   32'd0);
        check({tag, ".locked"},      32'(locked),      32'd0);
        check({tag, ".lock_lost"},   32'(lock_lost),   32'd0);
        check({tag, ".fault"},       32'(fault),       32'd0);
        check({tag, ".retry_count"}, 32'(retry_count), 32'd0);
        check({tag, ".state"},       32'(dbg_state),   32'(S_RESET));
        repeat (3) tick();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n  = 1'b1;
        pll_lock = 1'b0;
        #2;

        // Nominal bring-up, then loss in RUN, then lock chatter.
        do_reset("rst0", 1'b0);
        step_to(3);
        check("nom.pll_reset_held", 32'(pll_reset), 32'd1);
        check("nom.state_reset",    32'(dbg_state), 32'(S_RESET));
        step_to(4);
        check("nom.pll_reset_fall", 32'(pll_reset), 32'd0);
        check("nom.state_wait",     32'(dbg_state), 32'(S_WAIT));
        step_to(10);
        pll_lock = 1'b1;
        step_to(12);
        check("nom.sync_latency",   32'(dbg_state), 32'(S_WAIT));
        step_to(13);
        check("nom.state_stab",     32'(dbg_state), 32'(S_STAB));
        step_to(20);
        check("nom.rst_out_early",  32'(rst_out_n), 32'd0);
        check("nom.locked_early",   32'(locked),    32'd0);
        step_to(21);
        check("nom.rst_out_rise",   32'(rst_out_n), 32'd1);
        check("nom.locked_rise",    32'(locked),    32'd1);
        check("nom.retry_zero",     32'(retry_count), 32'd0);
        check("nom.state_run",      32'(dbg_state), 32'(S_RUN));

        step_to(23);
        pll_lock = 1'b0;
        step_to(25);
        check("loss.no_pulse_yet",  32'(lock_lost), 32'd0);
        check("loss.still_run",     32'(rst_out_n), 32'd1);
        step_to(26);
        check("loss.pulse",         32'(lock_lost), 32'd1);
        check("loss.rst_out_n",     32'(rst_out_n), 32'd0);
        check("loss.locked",        32'(locked),    32'd0);
        check("loss.pll_reset",     32'(pll_reset), 32'd1);
        check("loss.state",         32'(dbg_state), 32'(S_RESET));
        step_to(27);
        check("loss.pulse_end",     32'(lock_lost), 32'd0);
        step_to(30);
        check("loss.relock_wait",   32'(dbg_state), 32'(S_WAIT));
        check("loss.pll_reset_low", 32'(pll_reset), 32'd0);

        step_to(31);
        pll_lock = 1'b1;
        step_to(34);
        check("chat.stab1",         32'(dbg_state), 32'(S_STAB));
        step_to(36);
        pll_lock = 1'b0;
        step_to(37);
        pll_lock = 1'b1;
        step_to(38);
        check("chat.still_stab",    32'(dbg_state), 32'(S_STAB));
        check("chat.no_release",    32'(rst_out_n), 32'd0);
        step_to(39);
        check("chat.back_wait",     32'(dbg_state), 32'(S_WAIT));
        check("chat.retry_kept",    32'(retry_count), 32'd0);
        step_to(40);
        check("chat.stab2",         32'(dbg_state), 32'(S_STAB));
        step_to(47);
        check("chat.rst_out_early", 32'(rst_out_n), 32'd0);
        step_to(48);
        check("chat.rst_out_rise",  32'(rst_out_n), 32'd1);
        check("chat.locked",        32'(locked),    32'd1);
        check("chat.retry_zero",    32'(retry_count), 32'd0);

        // Single timeout, then lock; finish with an async reset in RUN.
        #3;
        do_reset("rst_run", 1'b0);
        step_to(23);
        check("to1.retry_before",   32'(retry_count), 32'd0);
        check("to1.pll_reset_low",  32'(pll_reset),   32'd0);
        step_to(24);
        check("to1.retry_inc",      32'(retry_count), 32'd1);
        check("to1.pll_reset_hi",   32'(pll_reset),   32'd1);
        check("to1.state_reset",    32'(dbg_state),   32'(S_RESET));
        step_to(27);
        check("to1.pll_reset_held", 32'(pll_reset),   32'd1);
        step_to(28);
        check("to1.pll_reset_fall", 32'(pll_reset),   32'd0);
        step_to(30);
        pll_lock = 1'b1;
        step_to(33);
        check("to1.state_stab",     32'(dbg_state),   32'(S_STAB));
        step_to(40);
        check("to1.retry_kept",     32'(retry_count), 32'd1);
        step_to(41);
        check("to1.retry_clear",    32'(retry_count), 32'd0);
        check("to1.locked",         32'(locked),      32'd1);
        step_to(43);
        #3;
        do_reset("rst_fail", 1'b0);

        // Two timeouts lead to FAIL; lock afterwards is ignored.
        step_to(47);
        check("fail.retry_before",  32'(retry_count), 32'd1);
        check("fail.fault_before",  32'(fault),       32'd0);
        check("fail.pll_rst_low",   32'(pll_reset),   32'd0);
        step_to(48);
        check("fail.fault",         32'(fault),       32'd1);
        check("fail.retry_sat",     32'(retry_count), 32'(MAX_RETRIES));
        check("fail.pll_reset",     32'(pll_reset),   32'd1);
        check("fail.state",         32'(dbg_state),   32'(S_FAIL));
        pll_lock = 1'b1;
        step_to(60);
        check("fail.sticky",        32'(fault),       32'd1);
        check("fail.pll_rst_hold",  32'(pll_reset),   32'd1);
        check("fail.no_release",    32'(rst_out_n),   32'd0);
        check("fail.state_hold",    32'(dbg_state),   32'(S_FAIL));
        check("fail.retry_hold",    32'(retry_count), 32'(MAX_RETRIES));

        // Async reset mid-STABILIZE, then restart from RESET_PLL.
        #3;
        do_reset("rst_clr", 1'b1);
        step_to(5);
        check("stab.entered",       32'(dbg_state), 32'(S_STAB));
        step_to(7);
        check("stab.pll_reset_low", 32'(pll_reset), 32'd0);
        #3;
        do_reset("rst_stab", 1'b1);
        step_to(3);
        check("rs.pll_reset_held",  32'(pll_reset), 32'd1);
        step_to(4);
        check("rs.pll_reset_fall",  32'(pll_reset), 32'd0);
        check("rs.state_wait",      32'(dbg_state), 32'(S_WAIT));
        step_to(5);
        check("rs.state_stab",      32'(dbg_state), 32'(S_STAB));
        step_to(12);
        check("rs.rst_out_early",   32'(rst_out_n), 32'd0);
        step_to(13);
        check("rs.rst_out_rise",    32'(rst_out_n), 32'd1);
        check("rs.state_run",       32'(dbg_state), 32'(S_RUN));

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
